// File: rtl/bus_iface_pkg.sv
// Shared constants for the memory bus interface: FSM states, owner codes, widths.
package bus_iface_pkg;

    localparam int unsigned AW_DEF = 20;
    localparam int unsigned DW     = 16;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned TO_W   = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic OWN_XU = 1'b0;
    localparam logic OWN_PF = 1'b1;

    localparam logic [DW-1:0] ERR_FILL = 16'hFFFF;

endpackage

// File: rtl/bus_iface_arb2.sv
// Two-way round-robin arbiter between the XU and prefetch ports; pointer flips after each grant.
module bus_arb2
    import bus_iface_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_xu,
    input  logic req_pf,
    input  logic gnt_en,
    output logic gnt_c,
    output logic own_c
);

    logic ptr;

    // Contention resolved by the pointer; a lone requester always wins.
    always_comb begin
        own_c = OWN_XU;
        if (req_xu && req_pf) begin
            own_c = ptr;
        end else if (req_pf) begin
            own_c = OWN_PF;
        end
        gnt_c = gnt_en && (req_xu || req_pf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= OWN_XU;
        end else if (gnt_c) begin
            ptr <= ~own_c;
        end
    end

endmodule

// File: rtl/bus_iface.sv
// Memory bus interface: arbitrates prefetch and XU ports onto a single-transaction SRAM bus
// with minimum wait states, ready extension and timeout.
module bus_iface
    import bus_iface_pkg::*;
#(
    parameter int unsigned WAIT    = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned AW      = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pf_req,
    input  logic [AW-1:0] pf_adr,
    output logic          pf_ack,
    output logic [15:0]   pf_dtr,
    input  logic          xu_req,
    input  logic          xu_we,
    input  logic [1:0]    xu_be,
    input  logic [AW-1:0] xu_adr,
    input  logic [15:0]   xu_wdata,
    output logic          xu_ack,
    output logic [15:0]   xu_rdata,
    output logic          bus_err,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [AW-1:0] mem_adr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_rdy
);

    logic [1:0]        state, state_d;
    logic              own, own_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic [TO_W-1:0]   to_cnt, to_d;
    logic              cs_d, we_d, pf_ack_d, xu_ack_d, err_d;
    logic [1:0]        be_d;
    logic [AW-1:0]     adr_d;
    logic [15:0]       wdata_d, pf_dtr_d, xu_rdata_d, fill;
    logic              rdy_hit, to_hit;
    logic              gnt_en, gnt_c, own_c;

    bus_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_xu (xu_req),
        .req_pf (pf_req),
        .gnt_en (gnt_en),
        .gnt_c  (gnt_c),
        .own_c  (own_c)
    );

    // Next-state and next-output logic; IDLE and DONE share the arbitration path.
    always_comb begin
        state_d    = state;
        own_d      = own;
        wait_d     = wait_cnt;
        to_d       = to_cnt;
        cs_d       = mem_cs;
        we_d       = mem_we;
        be_d       = mem_be;
        adr_d      = mem_adr;
        wdata_d    = mem_wdata;
        pf_ack_d   = 1'b0;
        xu_ack_d   = 1'b0;
        err_d      = 1'b0;
        pf_dtr_d   = pf_dtr;
        xu_rdata_d = xu_rdata;
        gnt_en     = 1'b0;
        rdy_hit    = 1'b0;
        to_hit     = 1'b0;
        fill       = ERR_FILL;

        case (state)
            ST_IDLE, ST_DONE: begin
                gnt_en  = 1'b1;
                state_d = ST_IDLE;
                if (gnt_c) begin
                    state_d = ST_ACCESS;
                    own_d   = own_c;
                    cs_d    = 1'b1;
                    wait_d  = WAIT_W'(WAIT);
                    to_d    = '0;
                    if (own_c == OWN_PF) begin
                        we_d    = 1'b0;
                        be_d    = 2'b11;
                        adr_d   = pf_adr;
                        wdata_d = '0;
                    end else begin
                        we_d    = xu_we;
                        be_d    = xu_be;
                        adr_d   = xu_adr;
                        wdata_d = xu_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                rdy_hit = (wait_cnt == '0) && mem_rdy;
                to_hit  = (to_cnt == TO_W'(TIMEOUT - 1));
                fill    = rdy_hit ? mem_rdata : ERR_FILL;
                to_d    = to_cnt + TO_W'(1);
                if (wait_cnt != '0) begin
                    wait_d = wait_cnt - WAIT_W'(1);
                end
                if (rdy_hit || to_hit) begin
                    state_d = ST_DONE;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    err_d   = !rdy_hit;
                    if (own == OWN_PF) begin
                        pf_ack_d = 1'b1;
                        pf_dtr_d = fill;
                    end else begin
                        xu_ack_d = 1'b1;
                        // Writes leave the read-data register untouched.
                        if (!mem_we) begin
                            xu_rdata_d = fill;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            own       <= OWN_XU;
            wait_cnt  <= '0;
            to_cnt    <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            pf_ack    <= 1'b0;
            xu_ack    <= 1'b0;
            bus_err   <= 1'b0;
            pf_dtr    <= '0;
            xu_rdata  <= '0;
        end else begin
            state     <= state_d;
            own       <= own_d;
            wait_cnt  <= wait_d;
            to_cnt    <= to_d;
            mem_cs    <= cs_d;
            mem_we    <= we_d;
            mem_be    <= be_d;
            mem_adr   <= adr_d;
            mem_wdata <= wdata_d;
            pf_ack    <= pf_ack_d;
            xu_ack    <= xu_ack_d;
            bus_err   <= err_d;
            pf_dtr    <= pf_dtr_d;
            xu_rdata  <= xu_rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_iface.sv
// Randomized scoreboard bench for bus_iface: a transaction-level bus model predicts grants and
// completions, an ack monitor pops the predictions, and directed sequences pin down exact latencies.
module tb_bus_iface;

    localparam int WAIT_C = 2;
    localparam int TO_C   = 8;

    logic        clk, rst;
    logic        pf_req, pf_ack;
    logic [19:0] pf_adr;
    logic [15:0] pf_dtr;
    logic        xu_req, xu_we, xu_ack;
    logic [1:0]  xu_be;
    logic [19:0] xu_adr;
    logic [15:0] xu_wdata, xu_rdata;
    logic        bus_err, mem_cs, mem_we, mem_rdy;
    logic [1:0]  mem_be;
    logic [19:0] mem_adr;
    logic [15:0] mem_wdata, mem_rdata;

    bus_iface #(.WAIT(WAIT_C), .TIMEOUT(TO_C), .AW(20)) dut (
        .clk(clk), .rst(rst),
        .pf_req(pf_req), .pf_adr(pf_adr), .pf_ack(pf_ack), .pf_dtr(pf_dtr),
        .xu_req(xu_req), .xu_we(xu_we), .xu_be(xu_be), .xu_adr(xu_adr),
        .xu_wdata(xu_wdata), .xu_ack(xu_ack), .xu_rdata(xu_rdata),
        .bus_err(bus_err), .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    typedef struct {
        bit          is_pf;
        logic [19:0] adr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] data;
        bit          err;
        int          cyc;
    } txn_t;

    typedef struct {
        int          cyc;
        bit          is_pf;
        bit          err;
        logic [15:0] data;
    } log_t;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    txn_t exp_q[$];
    log_t ack_log[$];
    bit   rdy_q[$];

    bit          model_busy = 0;
    bit          m_ptr_pf = 0;
    int          k = 0;
    txn_t        cur;
    txn_t        em;
    log_t        lg;
    logic [15:0] e_pf = '0;
    logic [15:0] e_xu = '0;
    bit          xu_known = 1;

    bit          rand_mode = 0;
    bit          auto_drop = 1;
    int unsigned rdy_pct = 100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Memory contents seen by the bench: one fixed word plus a hash of the address.
    function automatic logic [15:0] mem_f(input logic [19:0] a);
        if (a == 20'h00010) return 16'hA55A;
        return a[15:0] ^ {a[19:16], a[19:8]} ^ 16'h3C96;
    endfunction

    // Bus model: decides who is granted and when the access must finish.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_ctrl", {mem_cs, mem_we, mem_be, pf_ack, xu_ack, bus_err}, 32'd0);
            chk("rst_adr", mem_adr, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
            chk("rst_data", {pf_dtr, xu_rdata}, 32'd0);
            model_busy = 0;
            m_ptr_pf = 0;
            exp_q.delete();
        end else if (model_busy) begin
            if ((k >= WAIT_C && mem_rdy) || k == TO_C - 1) begin
                cur.err  = !(k >= WAIT_C && mem_rdy);
                cur.data = cur.err ? 16'hFFFF : mem_f(cur.adr);
                cur.cyc  = cyc;
                exp_q.push_back(cur);
                model_busy = 0;
                chk("cs_end", mem_cs, 32'd0);
            end else begin
                k++;
                chk("cs_hold", mem_cs, 32'd1);
                chk("adr_hold", mem_adr, cur.adr);
                chk("we_hold", mem_we, cur.we);
                chk("be_hold", mem_be, cur.be);
                if (!cur.is_pf) chk("wdata_hold", mem_wdata, cur.wdata);
            end
        end else begin
            chk("grant", mem_cs, xu_req || pf_req);
            if (xu_req || pf_req) begin
                cur.is_pf = (xu_req && pf_req) ? m_ptr_pf : pf_req;
                m_ptr_pf  = !cur.is_pf;
                cur.adr   = cur.is_pf ? pf_adr : xu_adr;
                cur.we    = cur.is_pf ? 1'b0 : xu_we;
                cur.be    = cur.is_pf ? 2'b11 : xu_be;
                cur.wdata = xu_wdata;
                model_busy = 1;
                k = 0;
                chk("g_adr", mem_adr, cur.adr);
                chk("g_we", mem_we, cur.we);
                chk("g_be", mem_be, cur.be);
                if (!cur.is_pf) chk("g_wdata", mem_wdata, cur.wdata);
            end
        end
    end

    // Ack monitor: pops predictions whenever the DUT acknowledges.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            e_pf = '0;
            e_xu = '0;
            xu_known = 1;
        end else begin
            if (pf_ack || xu_ack) begin
                lg.cyc = cyc;
                lg.is_pf = pf_ack;
                lg.err = bus_err;
                lg.data = pf_ack ? pf_dtr : xu_rdata;
                ack_log.push_back(lg);
                if (exp_q.size() == 0) begin
                    flag("unexpected_ack");
                end else begin
                    em = exp_q.pop_front();
                    chk("ack_owner", {pf_ack, xu_ack}, em.is_pf ? 32'd2 : 32'd1);
                    chk("ack_cycle", cyc, em.cyc);
                    chk("ack_err", bus_err, em.err);
                    if (em.is_pf) e_pf = em.data;
                    else if (!em.we) begin
                        e_xu = em.data;
                        xu_known = 1;
                    end else if (em.err) xu_known = 0;
                end
            end else begin
                chk("err_idle", bus_err, 32'd0);
                if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    flag("missing_ack");
                    void'(exp_q.pop_front());
                end
            end
            chk("pf_dtr", pf_dtr, e_pf);
            if (xu_known) chk("xu_rdata", xu_rdata, e_xu);
        end
    end

    // One negedge: requester handshakes, memory responder, optional random traffic.
    task automatic tick();
        @(negedge clk);
        if (auto_drop && xu_req && xu_ack) xu_req = 0;
        if (auto_drop && pf_req && pf_ack) pf_req = 0;
        if (rdy_q.size() != 0) mem_rdy = rdy_q.pop_front();
        else mem_rdy = ($urandom_range(0, 99) < rdy_pct);
        mem_rdata = mem_rdy ? mem_f(mem_adr) : 16'($urandom);
        if (rand_mode) begin
            if (!xu_req && $urandom_range(0, 2) == 0) begin
                xu_req = 1;
                xu_we = 1'($urandom);
                xu_be = 2'($urandom);
                if (xu_be == 2'b00) xu_be = 2'b11;
                xu_adr = 20'($urandom);
                xu_wdata = 16'($urandom);
            end
            if (!pf_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    pf_req = 1;
                    pf_adr = 20'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) pf_req = 0;
        end
    endtask

    task automatic wait_acks(input int n, input int max);
        int i = 0;
        while (ack_log.size() < n && i < max) begin
            tick();
            i++;
        end
        if (ack_log.size() < n) flag("ack_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int i;
        rst = 1; pf_req = 0; pf_adr = '0; xu_req = 0; xu_we = 0; xu_be = '0;
        xu_adr = '0; xu_wdata = '0; mem_rdy = 0; mem_rdata = '0;
        repeat (3) tick();
        rst = 0;
        repeat (2) tick();

        // Single prefetch read.
        ack_log.delete();
        tick(); c0 = cyc;
        pf_adr = 20'h00010; pf_req = 1;
        wait_acks(1, 20);
        if (ack_log.size() >= 1) begin
            chk("t1_lat", ack_log[0].cyc - c0, 32'd4);
            chk("t1_owner", ack_log[0].is_pf, 32'd1);
            chk("t1_data", ack_log[0].data, 32'hA55A);
            chk("t1_err", ack_log[0].err, 32'd0);
        end
        repeat (4) tick();

        // Both requesters held: strict alternation, XU first.
        ack_log.delete();
        auto_drop = 0;
        tick(); c0 = cyc;
        xu_we = 0; xu_be = 2'b11; xu_adr = 20'h00100; xu_req = 1;
        pf_adr = 20'h00200; pf_req = 1;
        i = 0;
        while (ack_log.size() < 4 && i < 40) begin
            tick();
            i++;
        end
        xu_req = 0; pf_req = 0; auto_drop = 1;
        if (ack_log.size() >= 4) begin
            for (int j = 0; j < 4; j++) begin
                chk("t2_cyc", ack_log[j].cyc - c0, 32'(4 * (j + 1)));
                chk("t2_owner", ack_log[j].is_pf, 32'(j % 2));
            end
        end else flag("t2_ack_count");
        repeat (4) tick();

        // XU write with three extra ready-low cycles.
        ack_log.delete();
        tick(); c0 = cyc;
        xu_we = 1; xu_be = 2'b01; xu_adr = 20'h00300; xu_wdata = 16'h1234; xu_req = 1;
        rdy_q = '{0, 0, 0, 0, 0, 1};
        wait_acks(1, 20);
        if (ack_log.size() >= 1) begin
            chk("t3_lat", ack_log[0].cyc - c0, 32'd7);
            chk("t3_owner", ack_log[0].is_pf, 32'd0);
            chk("t3_rdata", ack_log[0].data, mem_f(20'h00100));
        end
        repeat (3) tick();

        // Timeout, then a normal fetch.
        ack_log.delete();
        rdy_pct = 0;
        tick(); c0 = cyc;
        pf_adr = 20'h00400; pf_req = 1;
        wait_acks(1, 30);
        if (ack_log.size() >= 1) begin
            chk("t4_lat", ack_log[0].cyc - c0, 32'd9);
            chk("t4_err", ack_log[0].err, 32'd1);
            chk("t4_data", ack_log[0].data, 32'hFFFF);
        end
        rdy_pct = 100;
        tick(); c0 = cyc;
        pf_adr = 20'h00010; pf_req = 1;
        wait_acks(2, 20);
        if (ack_log.size() >= 2) begin
            chk("t4b_lat", ack_log[1].cyc - c0, 32'd4);
            chk("t4b_err", ack_log[1].err, 32'd0);
            chk("t4b_data", ack_log[1].data, 32'hA55A);
        end
        repeat (3) tick();

        // Prefetch request withdrawn after grant.
        ack_log.delete();
        tick(); c0 = cyc;
        pf_adr = 20'h00500; pf_req = 1;
        tick(); tick();
        pf_req = 0;
        wait_acks(1, 20);
        if (ack_log.size() >= 1) chk("t5_lat", ack_log[0].cyc - c0, 32'd4);
        repeat (6) tick();
        chk("t5_single", ack_log.size(), 32'd1);

        // Reset in the middle of an access, then XU-first priority.
        ack_log.delete();
        tick(); c0 = cyc;
        pf_adr = 20'h00600; pf_req = 1;
        tick(); tick();
        rst = 1; pf_req = 0;
        tick();
        rst = 0;
        repeat (5) tick();
        chk("t6_no_ack", ack_log.size(), 32'd0);
        tick();
        xu_we = 0; xu_be = 2'b11; xu_adr = 20'h00700; xu_req = 1;
        pf_adr = 20'h00800; pf_req = 1;
        wait_acks(1, 20);
        if (ack_log.size() >= 1) chk("t6_xu_first", ack_log[0].is_pf, 32'd0);
        wait_acks(2, 20);
        repeat (3) tick();

        // Random traffic: mostly-ready memory, then a slow memory that times out often.
        rand_mode = 1;
        rdy_pct = 75;
        repeat (3000) tick();
        rdy_pct = 15;
        repeat (2000) tick();
        rand_mode = 0;
        rdy_pct = 100;
        i = 0;
        while ((xu_req || pf_req || model_busy || exp_q.size() != 0) && i < 200) begin
            tick();
            i++;
        end
        if (xu_req || pf_req || model_busy) flag("drain_timeout");
        repeat (3) tick();
        chk("final_queue", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_iface.md
Name: bus_iface

Overview:
- Memory bus interface unit directly upstream of the instruction prefetch stage.
- Arbitrates between the prefetch word-fetch port (read-only) and the execution-unit (XU) data port (read/write).
- Runs one 16-bit transaction at a time on a synchronous SRAM-style external bus, with programmable minimum wait states, ready extension and a timeout.
- Returns data with a one-cycle ack pulse per completed transaction.

Parameters:
WAIT, 2, minimum access cycles after address phase before mem_rdy is honoured (1..15)
TIMEOUT, 255, max cycles in ACCESS before forced completion with error (WAIT < TIMEOUT <= 255)
AW, 20, word address width

Ports:
clk  in  1  Single clock, all logic on posedge
rst  in  1  Synchronous reset, active-high
pf_req  in  1  Prefetch request, level; may drop at any time
pf_adr  in  AW  Prefetch word address, sampled at grant
pf_ack  out  1  One-cycle pulse: pf_dtr valid this cycle
pf_dtr  out  16  Fetched word {hi byte, lo byte}
xu_req  in  1  XU request, level; held until xu_ack
xu_we  in  1  XU write enable, sampled at grant
xu_be  in  2  XU byte enables {hi, lo}, sampled at grant
xu_adr  in  AW  XU word address, sampled at grant
xu_wdata  in  16  XU write data, sampled at grant
xu_ack  out  1  One-cycle completion pulse
xu_rdata  out  16  Read data, valid with xu_ack on reads
bus_err  out  1  Pulses with the ack of a timed-out transaction
mem_cs  out  1  Bus cycle active
mem_we  out  1  Write strobe
mem_be  out  2  Byte enables
mem_adr  out  AW  Bus address
mem_wdata  out  16  Bus write data
mem_rdata  in  16  Bus read data
mem_rdy  in  1  Memory ready, sampled only once the wait counter reaches 0

Behaviour:
- Reset: all outputs are 0; state IDLE; priority pointer set to XU; wait and timeout counters cleared.
- Reset mid-transaction: the transaction is abandoned, mem_cs goes 0 on the next edge, and no ack or err is produced.

State machine: IDLE, ACCESS, DONE.

IDLE / DONE, arbitration:
- If both requests are high, the grant goes to the owner named by the priority pointer.
- If only one request is high, that requester is granted.
- On grant: latch owner, address, we, be and wdata into the bus registers; set mem_cs=1; load wait counter = WAIT and timeout counter = 0; go to ACCESS.
- Prefetch grants always use mem_we=0 and mem_be=2'b11.
- After every grant the pointer flips to the other owner, giving round-robin fairness.
- In DONE with no request pending, go to IDLE.

ACCESS:
- mem_* outputs are held stable.
- Wait counter decrements to 0 and saturates there; timeout counter increments each cycle.
- Normal completion: wait counter == 0 and mem_rdy == 1. Capture mem_rdata into the owner's data register, drop mem_cs, go to DONE.
- Timeout completion: timeout counter == TIMEOUT - 1 without normal completion. Load data register 16'hFFFF, set err, go to DONE.

DONE:
- Exactly one cycle long.
- The owner's ack is 1 this cycle; bus_err = err.
- Arbitration runs in the same cycle, so back-to-back transactions lose no extra cycle.

Timing and handshake rules:
- Latency: request first high in cycle 0 with bus idle → mem_cs cycles 1..WAIT+1 → ack in cycle WAIT+2. Throughput is one word per WAIT+2 cycles.
- Once granted, a transaction always completes, even if its request drops. Prefetch relies on this: it discards the stale ack after a flush.
- A request must be low or carry a new address in the cycle after its ack; otherwise it is re-granted.
- XU writes: xu_rdata is unchanged on write completion.
- pf_dtr and xu_rdata hold their value between acks.

Widths:
- Counters are 4-bit (wait) and 8-bit (timeout).
- No address arithmetic; addresses pass through unchanged.
- mem_rdy is ignored outside ACCESS.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ACCESS, DONE);
  - owner constants (OWN_XU, OWN_PF);
  - error-fill constant 16'hFFFF;
  - the AW default.
- One sub-module, bus_arb2: two-way round-robin arbiter with grant-enable input and pointer register, reset to XU.

Test Plan:
- Single prefetch read, WAIT=2, mem_rdy=1, pf_adr=20'h00010, mem_rdata=16'hA55A → mem_cs high cycles 1-3, pf_ack in cycle 4 with pf_dtr=16'hA55A, mem_we=0, mem_be=2'b11.
- xu_req and pf_req both held high from cycle 0 → grants alternate XU, PF, XU, PF; acks in cycles 4, 8, 12, 16.
- XU write, xu_be=2'b01, xu_wdata=16'h1234, mem_rdy low for 3 extra cycles → mem_be=2'b01 and mem_wdata=16'h1234 held throughout; xu_ack in cycle 7; xu_rdata unchanged.
- mem_rdy never asserted, TIMEOUT=8 → pf_ack and bus_err together in cycle 9; pf_dtr=16'hFFFF; next transaction proceeds normally.
- pf_req drops in cycle 2 of a granted fetch → pf_ack still pulses in cycle 4; no second grant follows.
- rst asserted in cycle 2 of ACCESS → all outputs 0 in cycle 3, no ack or err; a fresh request afterwards gets XU-first priority.
